jtag_bus_sequencer: RTL
=======================

// Module: jtag_bus_sequencer
// PURPOSE
//  Single-clock command engine behind the JTAGlet TAP's USEROP/USERDATA registers.
//  - Decodes each 8-bit userOp issued through the TAP and sequences one transaction on a simple req/ack memory bus.
//  - Maintains an auto-incrementing address pointer.
//  - Returns read data and status to the TAP through userData_in.
//  - Runs in the tck domain, between jtaglet and on-chip debug-accessible memory/registers.
// PARAMETERS
//  ADDR_W       32   bus address width; pointer wraps modulo 2^ADDR_W
//  ADDR_STEP    4    pointer increment for *_INC ops
//  TIMEOUT_CYC  255  max cycles in BUS waiting for bus_ack before abort (>=1)
// PORTS
//  tck           in   1       clock
//  trst          in   1       synchronous active-low reset
//  userOp        in   8       opcode from TAP USEROP register
//  userOp_ready  in   1       TAP update strobe for userOp; rising edge = new command
//  userData_out  in   32      operand from TAP USERDATA register
//  userData_in   out  32      read/status data captured by TAP USERDATA register
//  bus_req       out  1       transaction request, held until ack or timeout
//  bus_we        out  1       1=write, 0=read; valid while bus_req
//  bus_addr      out  ADDR_W  address; valid while bus_req
//  bus_wdata     out  32      write data; valid while bus_req
//  bus_rdata     in   32      read data; sampled on the edge where bus_ack=1
//  bus_ack       in   1       completion; only honoured while bus_req=1
//  busy          out  1       1 while state != IDLE
//  err           out  1       OR of sticky error bits
// BEHAVIOUR
//  Reset (trst=0 at posedge tck):
//  - State=IDLE; addr_ptr, userData_in, bus_* outputs and all sticky bits = 0.
//  - Reset mid-transaction: bus_req low after that edge; no data/pointer update.
//  Command detect:
//  - Rising edge of userOp_ready: registered previous value; start = ready & ~ready_q.
//  - A level held high triggers exactly once.
//  States IDLE -> BUS -> IDLE. Ops decoded in IDLE on the start edge:
//   0x00 NOP        no effect
//   0x01 SET_ADDR   addr_ptr <= userData_out[ADDR_W-1:0]; stays IDLE
//   0x02 WRITE      -> BUS, we=1, wdata=userData_out, addr=addr_ptr
//   0x03 READ       -> BUS, we=0, addr=addr_ptr
//   0x04 WRITE_INC  as WRITE; addr_ptr += ADDR_STEP on ack
//   0x05 READ_INC   as READ; addr_ptr += ADDR_STEP on ack
//   0x06 STATUS     userData_in <= {27'b0, busy, err_ovr, err_bad, err_to, 1'b1}; stays IDLE
//   0x07 CLR_ERR    clear all sticky error bits; stays IDLE
//   other           err_bad <= 1; stays IDLE
//  Timing and transaction rules:
//  - Start at edge k: bus_req/we/addr/wdata registered at edge k; busy=1 after edge k.
//  - In BUS, outputs are held stable; wait counter starts at 0 and increments per edge.
//  - bus_ack=1 at edge m: bus_req=0 after edge m; state IDLE.
//    - Read: userData_in <= bus_rdata.
//    - INC op: pointer updated, wrapping modulo 2^ADDR_W.
//    - Single-cycle minimum: ack on the first BUS edge is legal.
//  - Timeout: counter reaches TIMEOUT_CYC with no ack -> bus_req=0, err_to <= 1, state IDLE.
//    - Read timeout: userData_in <= 0. Pointer is not incremented.
//  - Ack and timeout on the same edge: ack wins, no error.
//  - New start while in BUS: command dropped, err_ovr <= 1; transaction continues.
//  - bus_ack while IDLE: ignored.
//  - Start on the same edge the BUS completes: still BUS at that edge, so the command is dropped with err_ovr.
//  - CLR_ERR at start while an error sets on that edge: the set wins.
//  - userData_in holds its last value except on read completion or STATUS.
// TESTING
//  1. Reset, SET_ADDR 0x1000, WRITE 0xCAFEF00D, ack after 3 cycles -> one bus_req pulse: we=1, addr=0x1000, wdata=0xCAFEF00D; busy low after ack edge.
//  2. SET_ADDR 0xFFFFFFFC, READ_INC, ack with rdata 0x12345678 -> userData_in=0x12345678; addr_ptr wraps to 0x00000000; next READ issues addr 0.
//  3. TIMEOUT_CYC=8, READ with no ack -> bus_req high exactly 8 cycles, then low; userData_in=0; err=1; STATUS reads 0x00000003.
//  4. Second userOp_ready rise during BUS -> ignored; err_ovr set (STATUS=0x00000009); CLR_ERR then STATUS -> 0x00000001, err=0.
//  5. userOp_ready held high 10 cycles with WRITE_INC -> exactly one bus transaction; pointer +4 once; opcode 0x55 -> err_bad (STATUS=0x00000005).
//  6. trst low mid-BUS -> bus_req=0 and busy=0 after that edge; addr_ptr=0; later bus_ack ignored; back-to-back ack-on-first-cycle transactions complete.

Source files
------------

// File: rtl/jtag_bus_sequencer.sv
// jtag_bus_sequencer: decodes 8-bit userOps from the JTAG TAP and runs one
// req/ack bus transaction per command. It keeps an auto-incrementing address
// pointer and returns read data or status through userData_in.
//
// Bus handshake: bus_req rises together with bus_we/bus_addr/bus_wdata. All four
// hold stable until the first tck edge that samples bus_ack=1 while bus_req=1.
// bus_rdata is captured on that edge, and bus_req drops after it. If no ack
// arrives within TIMEOUT_CYC edges, the request is withdrawn and err_to is set.
// bus_ack is ignored whenever bus_req is low.
module jtag_bus_sequencer #(
    parameter int ADDR_W      = 32,
    parameter int ADDR_STEP   = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              tck,
    input  logic              trst,
    input  logic [7:0]        userOp,
    input  logic              userOp_ready,
    input  logic [31:0]       userData_out,
    output logic [31:0]       userData_in,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    input  logic [31:0]       bus_rdata,
    input  logic              bus_ack,
    output logic              busy,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] OP_NOP       = 8'h00;
    localparam logic [7:0] OP_SET_ADDR  = 8'h01;
    localparam logic [7:0] OP_WRITE     = 8'h02;
    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_WRITE_INC = 8'h04;
    localparam logic [7:0] OP_READ_INC  = 8'h05;
    localparam logic [7:0] OP_STATUS    = 8'h06;
    localparam logic [7:0] OP_CLR_ERR   = 8'h07;

    typedef enum logic {S_IDLE, S_BUS} state_t;

    state_t              state_q, state_d;
    logic                ready_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                inc_q, inc_d;
    logic                err_to_q, err_to_d;
    logic                err_bad_q, err_bad_d;
    logic                err_ovr_q, err_ovr_d;
    logic [31:0]         data_d;
    logic                req_d, we_d;
    logic [ADDR_W-1:0]   baddr_d;
    logic [31:0]         wdata_d;
    logic                start;

    // A held-high ready level produces one command only.
    assign start = userOp_ready & ~ready_q;
    assign busy  = (state_q != S_IDLE);
    assign err   = err_to_q | err_bad_q | err_ovr_q;

    // Register the FSM state and all datapath/output registers.
    always_ff @(posedge tck) begin
        if (!trst) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b0;
            addr_q      <= '0;
            cnt_q       <= '0;
            inc_q       <= 1'b0;
            err_to_q    <= 1'b0;
            err_bad_q   <= 1'b0;
            err_ovr_q   <= 1'b0;
            userData_in <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= userOp_ready;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            inc_q       <= inc_d;
            err_to_q    <= err_to_d;
            err_bad_q   <= err_bad_d;
            err_ovr_q   <= err_ovr_d;
            userData_in <= data_d;
            bus_req     <= req_d;
            bus_we      <= we_d;
            bus_addr    <= baddr_d;
            bus_wdata   <= wdata_d;
        end
    end

    // Decode commands in IDLE, then track ack/timeout while a transaction is open.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        inc_d     = inc_q;
        err_to_d  = err_to_q;
        err_bad_d = err_bad_q;
        err_ovr_d = err_ovr_q;
        data_d    = userData_in;
        req_d     = bus_req;
        we_d      = bus_we;
        baddr_d   = bus_addr;
        wdata_d   = bus_wdata;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (userOp)
                        OP_NOP: ;
                        OP_SET_ADDR: addr_d = userData_out[ADDR_W-1:0];
                        OP_WRITE, OP_WRITE_INC: begin
                            state_d = S_BUS;
                            req_d   = 1'b1;
                            we_d    = 1'b1;
                            baddr_d = addr_q;
                            wdata_d = userData_out;
                            cnt_d   = '0;
                            inc_d   = (userOp == OP_WRITE_INC);
                        end
                        OP_READ, OP_READ_INC: begin
                            state_d = S_BUS;
                            req_d   = 1'b1;
                            we_d    = 1'b0;
                            baddr_d = addr_q;
                            cnt_d   = '0;
                            inc_d   = (userOp == OP_READ_INC);
                        end
                        OP_STATUS: data_d = {27'b0, busy, err_ovr_q, err_bad_q, err_to_q, 1'b1};
                        OP_CLR_ERR: begin
                            err_to_d  = 1'b0;
                            err_bad_d = 1'b0;
                            err_ovr_d = 1'b0;
                        end
                        default: err_bad_d = 1'b1;
                    endcase
                end
            end
            S_BUS: begin
                // Commands cannot queue behind an open transaction.
                if (start) err_ovr_d = 1'b1;
                if (bus_ack) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    if (!bus_we) data_d = bus_rdata;
                    if (inc_q) addr_d = addr_q + ADDR_W'(ADDR_STEP);
                end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_d  = S_IDLE;
                    req_d    = 1'b0;
                    err_to_d = 1'b1;
                    if (!bus_we) data_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
